cpu5_dmem_resp: RTL and testbench

- Data-memory responder, the target side of the core's load/store port: address, store data and load data.
- Owns a word-addressed RAM and serves one request at a time over a valid/ready request channel and a valid/ready response channel.
- Supports byte, half-word and word accesses, little-endian, with load sign/zero extension.
- A configurable wait-state counter models slow memory so the core's stall path can be exercised.

---
 rtl/cpu5_dmem_resp_pkg.sv | 39 +++
 rtl/cpu5_dmem_resp_if.sv | 34 +++
 rtl/cpu5_dmem_resp_lane.sv | 54 +++++
 rtl/cpu5_dmem_resp.sv | 140 ++++++++++++++
 tb/tb_cpu5_dmem_resp.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cpu5_dmem_resp_pkg.sv
// cpu5_dmem_resp shared types: data width, access-size codes, FSM states.
// No ports; imported by the responder, its lane helper and its interface.
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif
`ifndef CPU5_MEMSIZE_B
`define CPU5_MEMSIZE_B 2'b00
`endif
`ifndef CPU5_MEMSIZE_H
`define CPU5_MEMSIZE_H 2'b01
`endif
`ifndef CPU5_MEMSIZE_W
`define CPU5_MEMSIZE_W 2'b10
`endif
`ifndef CPU5_DMEM_ST_IDLE
`define CPU5_DMEM_ST_IDLE 2'b00
`endif
`ifndef CPU5_DMEM_ST_WAIT
`define CPU5_DMEM_ST_WAIT 2'b01
`endif
`ifndef CPU5_DMEM_ST_RESP
`define CPU5_DMEM_ST_RESP 2'b10
`endif

package cpu5_dmem_resp_pkg;

  localparam int XLEN = `CPU5_XLEN;

  localparam logic [1:0] MEMSIZE_B = `CPU5_MEMSIZE_B;
  localparam logic [1:0] MEMSIZE_H = `CPU5_MEMSIZE_H;
  localparam logic [1:0] MEMSIZE_W = `CPU5_MEMSIZE_W;

  typedef enum logic [1:0] {
    ST_IDLE = `CPU5_DMEM_ST_IDLE,
    ST_WAIT = `CPU5_DMEM_ST_WAIT,
    ST_RESP = `CPU5_DMEM_ST_RESP
  } dmem_st_e;

endpackage

// File: rtl/cpu5_dmem_resp_if.sv
// Load/store port between core (master) and data memory (slave).
// Request: valid/ready/we/addr/wdata/size/unsigned. Response: valid/ready/rdata/err.
interface cpu5_dmem_resp_if;
  import cpu5_dmem_resp_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_size, req_unsigned,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_size, req_unsigned,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );

endinterface

// File: rtl/cpu5_dmem_resp_lane.sv
// cpu5_dmem_lane: little-endian byte-lane steering for B/H/W accesses.
// In: size_i, lo_i (addr[1:0]), wdata_i, rword_i, uns_i. Out: be_o, wword_o, ldata_o, trap_o.
// CPU5_DMEM_MISALIGN_TRAP_EN makes trap_o flag misaligned H/W accesses.
module cpu5_dmem_lane
  import cpu5_dmem_resp_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  input  logic            uns_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wword_o,
  output logic [XLEN-1:0] ldata_o,
  output logic            trap_o
);

  logic [1:0]      lo;
  logic [XLEN-1:0] sh;

  always_comb begin
    lo      = lo_i;
    be_o    = 4'b1111;
    wword_o = wdata_i;
    trap_o  = 1'b0;
    case (size_i)
      MEMSIZE_B: begin
        be_o    = 4'b0001 << lo;
        wword_o = {4{wdata_i[7:0]}};
      end
      MEMSIZE_H: begin
`ifdef CPU5_DMEM_MISALIGN_TRAP_EN
        trap_o  = lo_i[0];
`endif
        lo      = {lo_i[1], 1'b0};
        be_o    = 4'b0011 << lo;
        wword_o = {2{wdata_i[15:0]}};
      end
      default: begin
`ifdef CPU5_DMEM_MISALIGN_TRAP_EN
        trap_o  = |lo_i;
`endif
        lo      = 2'b00;
      end
    endcase
    sh = rword_i >> {lo, 3'b000};
    case (size_i)
      MEMSIZE_B: ldata_o = {{(XLEN-8){~uns_i & sh[7]}}, sh[7:0]};
      MEMSIZE_H: ldata_o = {{(XLEN-16){~uns_i & sh[15]}}, sh[15:0]};
      default:   ldata_o = sh;
    endcase
  end

endmodule

// File: rtl/cpu5_dmem_resp.sv
// cpu5_dmem_resp: word-addressed data RAM serving one load/store at a time.
// Ports: clk, reset (async, active-high), bus (cpu5_dmem_resp_if.slave).
// Macro CPU5_DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses raise resp_err.
module cpu5_dmem_resp
  import cpu5_dmem_resp_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
)(
  input  logic             clk,
  input  logic             reset,
  cpu5_dmem_resp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  dmem_st_e        state_q;
  logic [3:0]      cnt_q;
  logic            we_q, uns_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [1:0]      size_q;
  logic            ready_q, valid_q, err_q;
  logic [XLEN-1:0] rdata_q;

  logic            in_idle, accept, exec;
  logic            a_we, a_uns, a_err;
  logic [XLEN-1:0] a_addr, a_wdata, a_rdata;
  logic [1:0]      a_size;
  logic [AW-1:0]   idx;
  logic            oor, trap;
  logic [3:0]      be;
  logic [XLEN-1:0] wword, ldata;

  assign in_idle = (state_q == ST_IDLE);
  assign accept  = in_idle & bus.req_valid & ready_q;

  // Zero wait states executes on the accept edge itself, so the
  // access is taken from the live bus there and from the capture later.
  assign a_we    = in_idle ? bus.req_we       : we_q;
  assign a_uns   = in_idle ? bus.req_unsigned : uns_q;
  assign a_addr  = in_idle ? bus.req_addr     : addr_q;
  assign a_wdata = in_idle ? bus.req_wdata    : wdata_q;
  assign a_size  = in_idle ? bus.req_size     : size_q;

  assign exec = (accept && (WAIT_CYCLES == 0)) ||
                (state_q == ST_WAIT && cnt_q == 4'd0);

  assign idx = a_addr[AW+1:2];
  assign oor = |a_addr[XLEN-1:AW+2];

  cpu5_dmem_lane u_lane (
    .size_i  (a_size),
    .lo_i    (a_addr[1:0]),
    .wdata_i (a_wdata),
    .rword_i (mem[idx]),
    .uns_i   (a_uns),
    .be_o    (be),
    .wword_o (wword),
    .ldata_o (ldata),
    .trap_o  (trap)
  );

  assign a_err   = oor | trap;
  assign a_rdata = (a_we | a_err) ? '0 : ldata;

  // RAM is not reset; a reset coinciding with the execute edge blocks the write.
  always_ff @(posedge clk) begin
    if (exec && a_we && !a_err && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              valid_q <= 1'b1;
              rdata_q <= a_rdata;
              err_q   <= a_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            valid_q <= 1'b1;
            rdata_q <= a_rdata;
            err_q   <= a_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_cpu5_dmem_resp.sv
// Bench for cpu5_dmem_resp: zero-wait and three-wait instances,
// expectations queued per request and checked on each response.
module tb_cpu5_dmem_resp;
  import cpu5_dmem_resp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3;
  bit   sel;
  logic d_valid, d_we, d_uns, d_rready;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;

  cpu5_dmem_resp_if b0();
  cpu5_dmem_resp_if b3();

  cpu5_dmem_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(rst0), .bus(b0));
  cpu5_dmem_resp #(.DEPTH(1024), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(rst3), .bus(b3));

  assign b0.req_valid    = !sel & d_valid;
  assign b0.req_we       = d_we;
  assign b0.req_addr     = d_addr;
  assign b0.req_wdata    = d_wdata;
  assign b0.req_size     = d_size;
  assign b0.req_unsigned = d_uns;
  assign b0.resp_ready   = !sel & d_rready;
  assign b3.req_valid    = sel & d_valid;
  assign b3.req_we       = d_we;
  assign b3.req_addr     = d_addr;
  assign b3.req_wdata    = d_wdata;
  assign b3.req_size     = d_size;
  assign b3.req_unsigned = d_uns;
  assign b3.resp_ready   = sel & d_rready;

  wire        o_rqr = sel ? b3.req_ready  : b0.req_ready;
  wire        o_rv  = sel ? b3.resp_valid : b0.resp_valid;
  wire        o_err = sel ? b3.resp_err   : b0.resp_err;
  wire [31:0] o_rd  = sel ? b3.resp_rdata : b0.resp_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(string tag, bit we, logic [31:0] addr,
                      logic [31:0] wdata, logic [1:0] size, bit uns,
                      int hold, bit pulse);
    logic [31:0] rd0;
    logic        err0;
    int          lat, n;
    bit          rr_bad, st_bad;
    exp_t        e;
    @(negedge clk);
    d_valid = 1'b1; d_we = we; d_addr = addr;
    d_wdata = wdata; d_size = size; d_uns = uns;
    n = 0;
    while (!o_rqr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".acc"}, {31'd0, o_rqr}, 32'd1);
    @(posedge clk); #1;
    d_valid = 1'b0;
    lat = 1; rr_bad = 1'b0; st_bad = 1'b0;
    while (!o_rv && lat < 50) begin
      if (o_rqr) rr_bad = 1'b1;
      if (pulse && lat == 2) begin
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h40;
        d_wdata = 32'h0000_0BAD; d_size = MEMSIZE_W;
      end else begin
        d_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    d_valid = 1'b0;
    e = sb.pop_front();
    chk({tag, ".lat"}, lat, e.lat);
    chk({tag, ".rd"}, o_rd, e.rd);
    chk({tag, ".err"}, {31'd0, o_err}, {31'd0, e.err});
    chk({tag, ".rqr"}, {31'd0, rr_bad}, 32'd0);
    rd0 = o_rd; err0 = o_err;
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        if (!o_rv || o_rqr || o_rd !== rd0 || o_err !== err0) st_bad = 1'b1;
      end
      chk({tag, ".hold"}, {31'd0, st_bad}, 32'd0);
    end
    @(negedge clk);
    d_rready = 1'b1;
    @(posedge clk); #1;
    d_rready = 1'b0;
    chk({tag, ".clr"}, {29'd0, o_rv, o_rqr, o_err}, 32'b010);
    chk({tag, ".clrd"}, o_rd, 32'd0);
  endtask

  task automatic go(string tag, bit we, logic [31:0] addr,
                    logic [31:0] wdata, logic [1:0] size, bit uns,
                    logic [31:0] xrd, logic xerr, int xlat,
                    int hold, bit pulse);
    exp_t e;
    e.rd = xrd; e.err = xerr; e.lat = xlat;
    sb.push_back(e);
    xact(tag, we, addr, wdata, size, uns, hold, pulse);
  endtask

  initial begin
    bit bad;
    rst0 = 1'b1; rst3 = 1'b1; sel = 1'b0;
    d_valid = 0; d_we = 0; d_uns = 0; d_rready = 0;
    d_addr = '0; d_wdata = '0; d_size = MEMSIZE_W;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #0;
      chk("rst.rqr", {31'd0, o_rqr}, 32'd1);
      chk("rst.rv", {31'd0, o_rv}, 32'd0);
      chk("rst.rd", o_rd, 32'd0);
      chk("rst.err", {31'd0, o_err}, 32'd0);
    end
    @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0; sel = 1'b0;

    go("stW",  1, 32'h10, 32'hDEADBEEF, MEMSIZE_W, 0, 32'h0, 0, 1, 0, 0);
    go("ldW",  0, 32'h10, 32'h0, MEMSIZE_W, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    go("stB",  1, 32'h11, 32'hAAAAAA7F, MEMSIZE_B, 0, 32'h0, 0, 1, 0, 0);
    go("ldW2", 0, 32'h10, 32'h0, MEMSIZE_W, 0, 32'hDEAD7FEF, 0, 1, 0, 0);
    go("ldBs", 0, 32'h13, 32'h0, MEMSIZE_B, 0, 32'hFFFFFFDE, 0, 1, 0, 0);
    go("ldBu", 0, 32'h13, 32'h0, MEMSIZE_B, 1, 32'h000000DE, 0, 1, 0, 0);
    go("ldHs", 0, 32'h12, 32'h0, MEMSIZE_H, 0, 32'hFFFFDEAD, 0, 1, 0, 0);
    go("ldHu", 0, 32'h12, 32'h0, MEMSIZE_H, 1, 32'h0000DEAD, 0, 1, 0, 0);
    go("ldB1", 0, 32'h11, 32'h0, MEMSIZE_B, 0, 32'h0000007F, 0, 1, 0, 0);
    go("ldWu", 0, 32'h10, 32'h0, MEMSIZE_W, 1, 32'hDEAD7FEF, 0, 1, 0, 0);
    go("st0",  1, 32'h0, 32'h01020304, MEMSIZE_W, 0, 32'h0, 0, 1, 0, 0);
    go("stOr", 1, 32'h1000, 32'hFFFFFFFF, MEMSIZE_W, 0, 32'h0, 1, 1, 0, 0);
    go("ldOr", 0, 32'h1000, 32'h0, MEMSIZE_W, 0, 32'h0, 1, 1, 0, 0);
    go("ld0",  0, 32'h0, 32'h0, MEMSIZE_W, 0, 32'h01020304, 0, 1, 0, 0);
    go("ld10", 0, 32'h10, 32'h0, MEMSIZE_W, 0, 32'hDEAD7FEF, 0, 1, 0, 0);
    go("st20", 1, 32'h20, 32'h0, MEMSIZE_W, 0, 32'h0, 0, 1, 0, 0);
`ifdef CPU5_DMEM_MISALIGN_TRAP_EN
    go("stHm", 1, 32'h21, 32'h1234BEEF, MEMSIZE_H, 0, 32'h0, 1, 1, 0, 0);
    go("ld20", 0, 32'h20, 32'h0, MEMSIZE_W, 0, 32'h0, 0, 1, 0, 0);
    go("ldWm", 0, 32'h13, 32'h0, MEMSIZE_W, 0, 32'h0, 1, 1, 0, 0);
`else
    go("stHm", 1, 32'h21, 32'h1234BEEF, MEMSIZE_H, 0, 32'h0, 0, 1, 0, 0);
    go("ld20", 0, 32'h20, 32'h0, MEMSIZE_W, 0, 32'h0000BEEF, 0, 1, 0, 0);
    go("ldWm", 0, 32'h13, 32'h0, MEMSIZE_W, 0, 32'hDEAD7FEF, 0, 1, 0, 0);
`endif

    sel = 1'b1;
    go("w3st",  1, 32'h40, 32'h55555555, MEMSIZE_W, 0, 32'h0, 0, 4, 0, 0);
    go("w3ld",  0, 32'h40, 32'h0, MEMSIZE_W, 0, 32'h55555555, 0, 4, 2, 1);
    go("w3ld2", 0, 32'h40, 32'h0, MEMSIZE_W, 0, 32'h55555555, 0, 4, 0, 0);
    go("w3st30", 1, 32'h30, 32'hCAFEF00D, MEMSIZE_W, 0, 32'h0, 0, 4, 0, 0);

    @(negedge clk);
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h30;
    d_wdata = 32'h11223344; d_size = MEMSIZE_W;
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(posedge clk); #3;
    chk("mid.wait", {30'd0, o_rqr, o_rv}, 32'b00);
    rst3 = 1'b1;
    #1;
    chk("mid.rst", {30'd0, o_rqr, o_rv}, 32'b10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_rv || !o_rqr) bad = 1'b1;
    end
    chk("mid.idle", {31'd0, bad}, 32'd0);
    go("w3ld30", 0, 32'h30, 32'h0, MEMSIZE_W, 0, 32'hCAFEF00D, 0, 4, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
